matrix_driver: RTL and testbench

MATRIX_DRIVER -- requirements
Module: matrix_driver

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/matrix_hold_timer.sv | 30 +++
 rtl/matrix_driver.sv | 133 +++++++++++++
 tb/tb_matrix_driver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and FSM encoding for the 16x16 LED matrix scanner.
// Pure declarations, no timing; no flow control.
// Imported by matrix_driver and matrix_hold_timer.
package matrix_pkg;

  localparam logic [15:0] BASE_ADDR_DEFAULT = 16'h0100;
  localparam int          ROWS              = 16;
  localparam int          COLS              = 16;
  localparam int          HOLD_CNT_W        = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    SETUP  = 3'd2,
    CLK_HI = 3'd3,
    LATCH  = 3'd4,
    HOLD   = 3'd5
  } state_t;

endpackage

// File: rtl/matrix_hold_timer.sv
// Row display timer: load arms it, done pulses on the last of HOLD_CYCLES cycles.
// Latency: done asserted HOLD_CYCLES cycles after the load cycle (first cycle after load counts as 1).
// No backpressure; load always restarts the count.
module matrix_hold_timer
  import matrix_pkg::*;
#(
  parameter int HOLD_CYCLES = 256
) (
  input  logic clk,
  input  logic reset_arduino,
  input  logic load,
  output logic done
);

  logic [HOLD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_arduino) begin
    if (!reset_arduino) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= HOLD_CNT_W'(HOLD_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - HOLD_CNT_W'(1);
    end
  end

  // Count reaching 1 marks the final display cycle, so HOLD lasts exactly HOLD_CYCLES.
  assign done = (cnt == HOLD_CNT_W'(1));

endmodule

// File: rtl/matrix_driver.sv
// Scans a 16x16 board from memory, shifts each row out serially, latches it and holds it lit.
// Latency: per row 3 cycles per column (zero-wait ack) + 1 latch + HOLD_CYCLES display cycles.
// Backpressure: mem_rd is held in READ until mem_ack; enable is only sampled in IDLE and at end of HOLD.
module matrix_driver
  import matrix_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          HOLD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_arduino,
  input  logic        enable,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        mat_sclk,
  output logic        mat_sdata,
  output logic        mat_latch,
  output logic        mat_oe_n,
  output logic [3:0]  row_sel,
  output logic        frame_done
);

  localparam logic [3:0] LAST_COL = 4'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_t     state, state_nxt;
  logic [3:0] row, col;
  logic       timer_done;
  logic       hold_done;
  logic       mem_data_unused;

  // Only the pixel bit of each board word is meaningful.
  assign mem_data_unused = ^mem_data[15:1];

  matrix_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk           (clk),
    .reset_arduino (reset_arduino),
    .load          (state == LATCH),
    .done          (timer_done)
  );

  assign hold_done = timer_done && (state == HOLD);
  assign mem_addr  = BASE_ADDR + {8'h00, row, col};

  always_ff @(posedge clk or negedge reset_arduino) begin
    if (!reset_arduino) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mat_sclk  = 1'b0;
    mat_latch = 1'b0;
    mat_oe_n  = 1'b1;
    case (state)
      IDLE: begin
        if (enable) state_nxt = READ;
      end
      READ: begin
        mem_rd = 1'b1;
        if (mem_ack) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = CLK_HI;
      end
      CLK_HI: begin
        mat_sclk  = 1'b1;
        state_nxt = (col == LAST_COL) ? LATCH : READ;
      end
      LATCH: begin
        mat_latch = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        mat_oe_n = 1'b0;
        if (hold_done) state_nxt = enable ? READ : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_arduino) begin
    if (!reset_arduino) begin
      row        <= '0;
      col        <= '0;
      mat_sdata  <= 1'b0;
      row_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          row <= '0;
          col <= '0;
        end
        READ: begin
          if (mem_ack) mat_sdata <= mem_data[0];
        end
        CLK_HI: begin
          if (col != LAST_COL) col <= col + 4'd1;
        end
        LATCH: begin
          row_sel <= row;
        end
        HOLD: begin
          // End of a row: rewind the column and advance, wrapping at the frame end.
          if (hold_done) begin
            col <= '0;
            if (row == LAST_ROW) begin
              row        <= '0;
              frame_done <= 1'b1;
            end else begin
              row <= row + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_driver.sv
// Scoreboard bench for matrix_driver: expected reads, shifted bits and latched rows are queued
// by the stimulus and consumed by an independent monitor sampling on the falling clock edge.
module tb_matrix_driver;

  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset_arduino;
  logic        enable;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        mat_sclk;
  logic        mat_sdata;
  logic        mat_latch;
  logic        mat_oe_n;
  logic [3:0]  row_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  matrix_driver #(
    .BASE_ADDR   (16'h0100),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk           (clk),
    .reset_arduino (reset_arduino),
    .enable        (enable),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .mat_sclk      (mat_sclk),
    .mat_sdata     (mat_sdata),
    .mat_latch     (mat_latch),
    .mat_oe_n      (mat_oe_n),
    .row_sel       (row_sel),
    .frame_done    (frame_done)
  );

  int checks = 0;
  int failures = 0;
  int wait_states = 0;
  int mode = 0;
  int exp_rd_len = 1;
  int frames_seen = 0;
  bit mon_en = 1'b0;

  logic [15:0] exp_addr_q[$];
  logic        exp_bit_q[$];
  logic [3:0]  exp_row_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Board contents: mode 0 diagonal with noisy upper bits, 1 all 0xFFFE, 2 all 0x0001.
  function automatic logic [15:0] word_for(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h0100;
    case (mode)
      0:       word_for = (off[7:4] == off[3:0]) ? 16'hA5A5 : 16'h5A5A;
      1:       word_for = 16'hFFFE;
      default: word_for = 16'h0001;
    endcase
  endfunction

  // bitmode 0: diagonal, 1: all zero, 2: all one
  task automatic push_rows(input int first_row, input int last_row, input int bitmode);
    for (int r = first_row; r <= last_row; r++) begin
      for (int c = 0; c < 16; c++) begin
        exp_addr_q.push_back(16'h0100 + 16'(r * 16 + c));
        if (bitmode == 0)      exp_bit_q.push_back(r == c);
        else if (bitmode == 1) exp_bit_q.push_back(1'b0);
        else                   exp_bit_q.push_back(1'b1);
      end
      exp_row_q.push_back(4'(r));
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_addr_q.size() == 0 && exp_bit_q.size() == 0 && exp_row_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queues_drained", 32'(exp_addr_q.size() + exp_bit_q.size() + exp_row_q.size()), 32'd0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (frames_seen >= n) break;
      @(negedge clk);
    end
    chk("frames_seen", 32'(frames_seen), 32'(n));
  endtask

  task automatic wait_addr(input logic [15:0] a, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == a) break;
    end
    chk("reach_addr", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, a});
  endtask

  // Memory responder: acks after wait_states extra cycles of mem_rd.
  initial begin : memory
    int cyc;
    cyc      = 0;
    mem_ack  = 1'b0;
    mem_data = 16'hFFFF;
    forever begin
      @(negedge clk);
      if (mem_rd && reset_arduino) begin
        cyc++;
        if (cyc > wait_states) begin
          mem_ack  = 1'b1;
          mem_data = word_for(mem_addr);
          cyc      = 0;
        end else begin
          mem_ack  = 1'b0;
          mem_data = 16'hFFFF;
        end
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'hFFFF;
        cyc      = 0;
      end
    end
  end

  initial begin : monitor
    logic        prev_rd;
    logic        prev_oe_n;
    int          rd_len;
    int          oe_len;
    logic [15:0] rd_addr;
    prev_rd   = 1'b0;
    prev_oe_n = 1'b1;
    rd_len    = 0;
    oe_len    = 0;
    rd_addr   = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_rd && !prev_rd) begin
          rd_addr = mem_addr;
          if (exp_addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read: got addr %0h expected no read", mem_addr);
          end else begin
            chk("read_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
          end
        end else if (mem_rd) begin
          chk("addr_stable", 32'(mem_addr), 32'(rd_addr));
        end
        if (mem_rd) chk("no_sclk_in_read", 32'(mat_sclk), 32'd0);
        if (!mem_rd && prev_rd) chk("rd_len", 32'(rd_len), 32'(exp_rd_len));
        if (mat_sclk) begin
          if (exp_bit_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_shift: got sdata %0b expected no shift", mat_sdata);
          end else begin
            chk("shift_bit", 32'(mat_sdata), 32'(exp_bit_q.pop_front()));
          end
        end
        if (!mat_oe_n && prev_oe_n) begin
          if (exp_row_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_hold: got row_sel %0d expected no hold", row_sel);
          end else begin
            chk("latched_row", 32'(row_sel), 32'(exp_row_q.pop_front()));
          end
        end
        if (mat_oe_n && !prev_oe_n) chk("hold_len", 32'(oe_len), 32'(HOLD));
        if (frame_done) begin
          frames_seen++;
          chk("frame_done_after_row15", {27'd0, prev_oe_n, row_sel}, {27'd0, 1'b0, 4'hF});
        end
      end
      rd_len    = mem_rd ? rd_len + 1 : 0;
      oe_len    = !mat_oe_n ? oe_len + 1 : 0;
      prev_rd   = mem_rd;
      prev_oe_n = mat_oe_n;
    end
  end

  initial begin : stimulus
    reset_arduino = 1'b0;
    enable        = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_mem_rd",     32'(mem_rd),     32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'h0100);
    chk("rst_sclk",       32'(mat_sclk),   32'd0);
    chk("rst_sdata",      32'(mat_sdata),  32'd0);
    chk("rst_latch",      32'(mat_latch),  32'd0);
    chk("rst_oe_n",       32'(mat_oe_n),   32'd1);
    chk("rst_row_sel",    32'(row_sel),    32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    reset_arduino = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Diagonal frame, wrap into the next frame, drop enable during row 5.
    mode        = 0;
    wait_states = 0;
    exp_rd_len  = 1;
    push_rows(0, 15, 0);
    push_rows(0, 5, 0);
    enable = 1'b1;
    wait_frames(1, 2000);
    wait_addr(16'h0150, 500);
    enable = 1'b0;
    wait_drain(1000);
    repeat (20) @(negedge clk);
    chk("idle_mem_rd", 32'(mem_rd),   32'd0);
    chk("idle_oe_n",   32'(mat_oe_n), 32'd1);
    chk("idle_frames", 32'(frames_seen), 32'd1);

    // Three wait states, upper bits set and pixel bit clear everywhere.
    mode        = 1;
    wait_states = 3;
    exp_rd_len  = 4;
    push_rows(0, 15, 1);
    enable = 1'b1;
    wait_addr(16'h01F0, 3000);
    enable = 1'b0;
    wait_drain(500);
    wait_frames(2, 200);

    // Only the pixel bit set everywhere.
    mode        = 2;
    wait_states = 0;
    exp_rd_len  = 1;
    push_rows(0, 15, 2);
    enable = 1'b1;
    wait_addr(16'h01F0, 2000);
    enable = 1'b0;
    wait_drain(500);
    wait_frames(3, 200);

    // Reset in the middle of a column clock pulse.
    mon_en = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mat_sclk) break;
    end
    chk("pre_reset_sclk", 32'(mat_sclk), 32'd1);
    reset_arduino = 1'b0;
    #1;
    chk("mid_rst_sclk",  32'(mat_sclk), 32'd0);
    chk("mid_rst_oe_n",  32'(mat_oe_n), 32'd1);
    chk("mid_rst_rd",    32'(mem_rd),   32'd0);
    chk("mid_rst_sdata", 32'(mat_sdata), 32'd0);
    repeat (2) @(negedge clk);
    reset_arduino = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd) break;
    end
    chk("post_rst_rd",   32'(mem_rd),   32'd1);
    chk("post_rst_addr", 32'(mem_addr), 32'h0100);

    enable = 1'b0;
    reset_arduino = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
